// File: rtl/group_credit_fifo_if.sv
// Row handshake bundle between the SFTM (write side) and the DPM (read side).
// The slave modport is the FIFO's view. The master modport is the view of the producer and consumer.
interface group_credit_fifo_if #(
    parameter int DATA_W = 64
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (
        output wr_valid, wr_data, wr_last, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/group_credit_fifo.sv
// Credit-managed FWFT row FIFO: each group start takes a credit, and each drained group returns one.
// Optional watermark flag: define GCF_WATERMARK_EN to build the registered almost_full.
module group_credit_fifo #(
    parameter int DATA_W      = 64,
    parameter int FIFO_DEPTH  = 8,
    parameter int MAX_CREDITS = 2,
    parameter int GROUP_ROWS  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    group_credit_fifo_if.slave  bus,
    output logic                fifo_full_o,
    output logic                fifo_empty_o,
    output logic [3:0]          fifo_count_o,
    output logic                credit_available_o,
    output logic [1:0]          credits_o,
    output logic                group_err_o,
    output logic                credit_err_o,
    output logic                almost_full_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [1:0] MAX_CR = 2'(MAX_CREDITS);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic {G_IDLE = 1'b0, G_OPEN = 1'b1} grp_state_e;

    entry_t            mem_q [FIFO_DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [3:0]        count_q, count_d;
    logic [1:0]        credits_q, credits_d;
    grp_state_e        grp_q, grp_d;
    logic [3:0]        row_cnt_q, row_cnt_d, row_nxt;
    logic              group_err_q, credit_err_q;
    logic              wr_ready, rd_valid, push, pop;
    logic              at_len, close_row, len_bad, consume, ret;

    assign head     = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != 4'd0);
    assign wr_ready = (count_q != 4'(FIFO_DEPTH)) & ((grp_q == G_OPEN) | (credits_q != 2'd0));
    assign push     = bus.wr_valid & wr_ready;
    assign pop      = rd_valid & bus.rd_ready;
    assign ret      = pop & head.last;
    assign row_nxt  = row_cnt_q + 4'd1;
    assign at_len   = (row_nxt == 4'(GROUP_ROWS));

    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = rd_valid;
    // Output is zero when the FIFO is empty, so no stale entry appears after a reset or flush.
    assign bus.rd_data  = rd_valid ? head.data : '0;
    assign bus.rd_last  = rd_valid & head.last;

    assign fifo_full_o        = (count_q == 4'(FIFO_DEPTH));
    assign fifo_empty_o       = (count_q == 4'd0);
    assign fifo_count_o       = count_q;
    assign credits_o          = credits_q;
    assign credit_available_o = (credits_q != 2'd0);
    assign group_err_o        = group_err_q;
    assign credit_err_o       = credit_err_q;

    // Group tracker: a group closes on wr_last or when it reaches GROUP_ROWS rows.
    always_comb begin
        grp_d     = grp_q;
        row_cnt_d = row_cnt_q;
        close_row = 1'b0;
        len_bad   = 1'b0;
        consume   = 1'b0;
        if (push) begin
            close_row = bus.wr_last | at_len;
            len_bad   = bus.wr_last ^ at_len;
            consume   = (grp_q == G_IDLE);
            if (close_row) begin
                grp_d     = G_IDLE;
                row_cnt_d = 4'd0;
            end else begin
                grp_d     = G_OPEN;
                row_cnt_d = row_nxt;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
        credits_d = credits_q;
        if (consume && !ret)
            credits_d = credits_q - 2'd1;
        else if (ret && !consume && credits_q != MAX_CR)
            credits_d = credits_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= 4'd0;
            credits_q    <= MAX_CR;
            grp_q        <= G_IDLE;
            row_cnt_q    <= 4'd0;
            group_err_q  <= 1'b0;
            credit_err_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 4'd0;
            credits_q <= MAX_CR;
            grp_q     <= G_IDLE;
            row_cnt_q <= 4'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q      <= count_d;
            credits_q    <= credits_d;
            grp_q        <= grp_d;
            row_cnt_q    <= row_cnt_d;
            group_err_q  <= group_err_q | len_bad;
            credit_err_q <= credit_err_q | (ret & (credits_q == MAX_CR));
        end
    end

    // Storage holds no reset value, because the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= {close_row, bus.wr_data};
    end

`ifdef GCF_WATERMARK_EN
    localparam logic [3:0] AF_HI = 4'((FIFO_DEPTH * 3) / 4);
    localparam logic [3:0] AF_LO = 4'(FIFO_DEPTH / 4);
    logic af_q, af_d;

    // Hysteresis: set at the high mark, clear at the low mark, and hold between them.
    always_comb begin
        af_d = af_q;
        if (count_d >= AF_HI)      af_d = 1'b1;
        else if (count_d <= AF_LO) af_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       af_q <= 1'b0;
        else if (flush_i) af_q <= 1'b0;
        else              af_q <= af_d;
    end

    assign almost_full_o = af_q;
`else
    assign almost_full_o = 1'b0;
`endif
endmodule

// File: tb/tb_group_credit_fifo.sv
// Randomized and directed bench for group_credit_fifo against a queue-based group/credit model.
module tb_group_credit_fifo;
    localparam int DW = 64, DEPTH = 8, MAXC = 2, GR = 4;
`ifdef GCF_WATERMARK_EN
    localparam bit WM_ON = 1'b1;
`else
    localparam bit WM_ON = 1'b0;
`endif

    logic clk, rst_n, flush;
    logic full, empty, cavail, gerr, cerr, af;
    logic [3:0] count;
    logic [1:0] credits;
    int errors = 0, checks = 0;

    group_credit_fifo_if #(.DATA_W(DW)) bus ();

    group_credit_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_CREDITS(MAXC), .GROUP_ROWS(GR)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(bus),
        .fifo_full_o(full), .fifo_empty_o(empty), .fifo_count_o(count),
        .credit_available_o(cavail), .credits_o(credits),
        .group_err_o(gerr), .credit_err_o(cerr), .almost_full_o(af)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: row queue plus group/credit bookkeeping from the rules.
    typedef struct { bit last; logic [DW-1:0] data; } ent_t;
    ent_t mq[$];
    int   m_credits, m_rows;
    bit   m_open, m_gerr, m_cerr, m_af;

    function automatic bit m_wr_ready();
        return (mq.size() != DEPTH) && (m_open || m_credits > 0);
    endfunction

    task automatic m_clear(input bit hard);
        mq.delete();
        m_credits = MAXC; m_rows = 0; m_open = 0; m_af = 0;
        if (hard) begin m_gerr = 0; m_cerr = 0; end
    endtask

    task automatic m_step(input bit pu, input bit po, input bit wl, input logic [DW-1:0] wd, input bit fl);
        int n, used;
        ent_t e;
        if (fl) begin m_clear(0); return; end
        used = (pu && !m_open) ? 1 : 0;
        if (po) begin
            e = mq.pop_front();
            if (e.last) begin
                if (m_credits == MAXC) m_cerr = 1;
                m_credits = m_credits + 1;
            end
        end
        m_credits = m_credits - used;
        if (m_credits > MAXC) m_credits = MAXC;
        if (pu) begin
            n = m_rows + 1;
            if (wl != (n == GR)) m_gerr = 1;
            e.last = wl || (n == GR);
            e.data = wd;
            mq.push_back(e);
            m_open = !e.last;
            m_rows = e.last ? 0 : n;
        end
`ifdef GCF_WATERMARK_EN
        if (mq.size() >= (DEPTH * 3) / 4) m_af = 1;
        else if (mq.size() <= DEPTH / 4) m_af = 0;
`endif
    endtask

    task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit wl, input bit rr,
                         input bit fl, output bit pushed);
        bit pu, po;
        bus.wr_valid = wv; bus.wr_data = wd; bus.wr_last = wl; bus.rd_ready = rr; flush = fl;
        pu = wv && m_wr_ready();
        po = rr && (mq.size() != 0);
        @(posedge clk);
        m_step(pu, po, wl, wd, fl);
        #1;
        pushed = pu && !fl;
    endtask

    task automatic do_reset();
        bus.wr_valid = 0; bus.wr_data = '0; bus.wr_last = 0; bus.rd_ready = 0; flush = 0;
        rst_n = 0;
        #2;
        m_clear(1);
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({count, empty, full, bus.rd_valid, bus.rd_last} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_fifo: got cnt=%0d emp=%0b full=%0b rdv=%0b rdl=%0b want 0 1 0 0 0", count, empty, full, bus.rd_valid, bus.rd_last); end
        checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
        checks++; if ({credits, cavail, gerr, cerr, af, bus.wr_ready} !== {2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_status: got cr=%0d ca=%0b ge=%0b ce=%0b af=%0b wrr=%0b want 2 1 0 0 0 1", credits, cavail, gerr, cerr, af, bus.wr_ready); end
    endtask

    task automatic test_group_fill();
        bit ok;
        logic [DW-1:0] d [4];
        do_reset();
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        cycle(1, d[0], 0, 0, 0, ok);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== d[0]) begin
            errors++; $display("FAIL fill_fwft: got rdv=%0b data=%h want 1 %h", bus.rd_valid, bus.rd_data, d[0]); end
        for (int i = 1; i < 4; i++) cycle(1, d[i], i == 3, 0, 0, ok);
        cycle(0, '0, 0, 0, 0, ok);
        checks++; if (count !== 4'd4 || credits !== 2'd1) begin
            errors++; $display("FAIL fill_count_credits: got cnt=%0d cr=%0d want 4 1", count, credits); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rd_last !== (i == 3) || bus.rd_data !== d[i]) begin
                errors++; $display("FAIL fill_entry%0d: got last=%0b data=%h want %0b %h", i, bus.rd_last, bus.rd_data, i == 3, d[i]); end
            cycle(0, '0, 0, 1, 0, ok);
        end
        checks++; if (credits !== 2'd2 || empty !== 1'b1) begin
            errors++; $display("FAIL fill_drain: got cr=%0d emp=%0b want 2 1", credits, empty); end
    endtask

    task automatic test_credit_stall();
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, DW'(i), (i % 4) == 3, 0, 0, ok);
        bus.wr_valid = 1; #1;
        checks++; if ({bus.wr_ready, credits, count, full} !== {1'b0, 2'd0, 4'd8, 1'b1}) begin
            errors++; $display("FAIL stall_full: got wrr=%0b cr=%0d cnt=%0d full=%0b want 0 0 8 1", bus.wr_ready, credits, count, full); end
        for (int i = 0; i < 3; i++) cycle(1, 64'hdead, 0, 1, 0, ok);
        checks++; if (bus.wr_ready !== 1'b0 || credits !== 2'd0) begin
            errors++; $display("FAIL stall_no_credit: got wrr=%0b cr=%0d want 0 0", bus.wr_ready, credits); end
        cycle(1, 64'hdead, 0, 1, 0, ok);
        checks++; if (credits !== 2'd1 || count !== 4'd4 || bus.wr_ready !== 1'b1) begin
            errors++; $display("FAIL stall_return: got cr=%0d cnt=%0d wrr=%0b want 1 4 1", credits, count, bus.wr_ready); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [DW-1:0] d [16];
        int bad = 0;
        do_reset();
        for (int i = 0; i < 16; i++) d[i] = {$urandom, $urandom};
        for (int i = 0; i < 16; i++) begin
            cycle(1, d[i], (i % 4) == 3, 1, 0, ok);
            if (!ok || count !== 4'd1 || bus.rd_data !== d[i]) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_stream: got %0d bad cycles want 0", bad); end
        cycle(0, '0, 0, 1, 0, ok);
        checks++; if ({empty, credits, gerr, cerr} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin
            errors++; $display("FAIL b2b_end: got emp=%0b cr=%0d ge=%0b ce=%0b want 1 2 0 0", empty, credits, gerr, cerr); end
    endtask

    task automatic test_group_err();
        bit ok;
        bit exp_last [5] = '{0, 0, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, DW'(i), i == 2, 0, 0, ok);
        checks++; if (gerr !== 1'b1 || credits !== 2'd1) begin
            errors++; $display("FAIL gerr_short: got ge=%0b cr=%0d want 1 1", gerr, credits); end
        for (int i = 0; i < 4; i++) cycle(1, DW'(i), i == 3, 1, 0, ok);
        checks++; if (gerr !== 1'b1) begin errors++; $display("FAIL gerr_sticky: got %0b want 1", gerr); end
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, DW'(i), 0, 0, 0, ok);
        checks++; if ({gerr, count, credits, bus.wr_ready} !== {1'b1, 4'd5, 2'd0, 1'b1}) begin
            errors++; $display("FAIL gerr_long: got ge=%0b cnt=%0d cr=%0d wrr=%0b want 1 5 0 1", gerr, count, credits, bus.wr_ready); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.rd_last !== exp_last[i]) begin
                errors++; $display("FAIL gerr_last%0d: got %0b want %0b", i, bus.rd_last, exp_last[i]); end
            cycle(0, '0, 0, 1, 0, ok);
        end
    endtask

    task automatic test_flush();
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, DW'(i), 0, 0, 0, ok);
        cycle(1, 64'hf1, 0, 0, 1, ok);
        checks++; if ({count, empty, credits, bus.rd_valid} !== {4'd0, 1'b1, 2'd2, 1'b0}) begin
            errors++; $display("FAIL flush_clear: got cnt=%0d emp=%0b cr=%0d rdv=%0b want 0 1 2 0", count, empty, credits, bus.rd_valid); end
        checks++; if (gerr !== 1'b1 || cerr !== 1'b0) begin
            errors++; $display("FAIL flush_errs: got ge=%0b ce=%0b want 1 0", gerr, cerr); end
        cycle(1, 64'h77, 0, 0, 0, ok);
        checks++; if (count !== 4'd1 || credits !== 2'd1 || bus.rd_data !== 64'h77) begin
            errors++; $display("FAIL flush_restart: got cnt=%0d cr=%0d data=%h want 1 1 77", count, credits, bus.rd_data); end
    endtask

    task automatic test_watermark();
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, DW'(i), i == 3, 0, 0, ok);
        checks++; if (af !== 1'b0) begin errors++; $display("FAIL wm_at5: got %0b want 0", af); end
        cycle(1, 64'h5, 0, 0, 0, ok);
        checks++; if (af !== WM_ON) begin errors++; $display("FAIL wm_at6: got %0b want %0b", af, WM_ON); end
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 1, 0, ok);
        checks++; if (af !== WM_ON || count !== 4'd3) begin
            errors++; $display("FAIL wm_at3: got af=%0b cnt=%0d want %0b 3", af, count, WM_ON); end
        cycle(0, '0, 0, 1, 0, ok);
        checks++; if (af !== 1'b0 || count !== 4'd2) begin
            errors++; $display("FAIL wm_at2: got af=%0b cnt=%0d want 0 2", af, count); end
    endtask

    task automatic test_random();
        bit ok, wv, wl, rr, fl;
        logic [14:0] exp_v, obs_v;
        logic [DW-1:0] exp_d;
        int bad_v = 0, bad_d = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            wv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 99) == 0);
            if (m_rows == GR - 1) wl = ($urandom_range(0, 19) != 0);
            else                  wl = ($urandom_range(0, 29) == 0);
            cycle(wv, {$urandom, $urandom}, wl, rr, fl, ok);
            exp_d = (mq.size() != 0) ? mq[0].data : '0;
            exp_v = {mq.size() != 0, (mq.size() != 0) && mq[0].last, mq.size() == DEPTH, mq.size() == 0,
                     4'(mq.size()), 2'(m_credits), m_credits != 0, m_wr_ready(), m_gerr, m_cerr, m_af};
            obs_v = {bus.rd_valid, bus.rd_last, full, empty, count, credits, cavail, bus.wr_ready, gerr, cerr, af};
            checks++; if (obs_v !== exp_v) begin
                errors++; bad_v++;
                if (bad_v <= 5) $display("FAIL rand_status c=%0d: got %b want %b", c, obs_v, exp_v);
            end
            checks++; if (bus.rd_data !== exp_d) begin
                errors++; bad_d++;
                if (bad_d <= 5) $display("FAIL rand_data c=%0d: got %h want %h", c, bus.rd_data, exp_d);
            end
        end
    endtask

    initial begin
        rst_n = 0; flush = 0;
        bus.wr_valid = 0; bus.wr_data = '0; bus.wr_last = 0; bus.rd_ready = 0;
        #12;
        test_reset();
        test_group_fill();
        test_credit_stall();
        test_back_to_back();
        test_group_err();
        test_flush();
        test_watermark();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end
endmodule
